// File: rtl/timer_display_pkg.sv
// timer_display_pkg: shared FSM state type, seven-segment table and BCD helpers
package timer_display_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_TABLE [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  localparam logic [31:0] DISP_MAX = 32'h9999_9999;
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    return d > 4'd9 ? SEG_BLANK : SEG_TABLE[d];
  endfunction
  function automatic logic [39:0] dabble(input logic [39:0] b);
    logic [39:0] r;
    for (int i = 0; i < 10; i++)
      r[4*i +: 4] = b[4*i +: 4] >= 4'd5 ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    return r;
  endfunction
endpackage

// File: rtl/timer_display_if.sv
// timer_display_if: timer value in, multiplexed display and status flags out
interface timer_display_if;
  logic [31:0] value;
  logic        blank_zeros;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic        ovf;
  logic        expired;
  modport master (output value, blank_zeros, input seg, an, ovf, expired);
  modport slave  (input value, blank_zeros, output seg, an, ovf, expired);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 32-bit binary to 10-digit BCD, one shift-add-3 step per cycle
module bin2bcd_seq
  import timer_display_pkg::*;
(
  input  logic        clk_cpu,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] bin,
  output logic        busy,
  output logic        done,
  output logic [39:0] bcd
);
  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [31:0] sh;
  // state register and double-dabble datapath; bcd holds its result until the next start
  always_ff @(posedge clk_cpu) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
      bcd   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        sh  <= bin;
        bcd <= '0;
        cnt <= '0;
      end else if (state == SHIFT) begin
        {bcd, sh} <= {dabble(bcd), sh} << 1;
        cnt       <= cnt + 5'd1;
      end
    end
  end
  // next state: 32 shift cycles, then a single DONE cycle
  always_comb begin
    state_nx = state;
    busy     = state != IDLE;
    done     = state == DONE;
    if (state == IDLE && start) state_nx = SHIFT;
    if (state == SHIFT && cnt == 5'd31) state_nx = DONE;
    if (state == DONE) state_nx = IDLE;
  end
endmodule

// File: rtl/timer_display.sv
// timer_display: countdown value to 8-digit multiplexed seven-segment display
module timer_display
  import timer_display_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic           clk_cpu,
  input  logic           rst_n,
  timer_display_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  logic [31:0]   last;
  logic          first;
  logic          start, busy, done;
  logic [39:0]   bcd;
  logic [31:0]   disp;
  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [3:0]    digit;
  logic          blank;
  assign start = !busy && (first || bus.value != last);
  assign digit = disp[{idx, 2'b00} +: 4];
  assign blank = bus.blank_zeros && idx != 3'd0 && (disp >> {idx, 2'b00}) == 32'd0;
  bin2bcd_seq u_conv (
    .clk_cpu (clk_cpu),
    .rst_n   (rst_n),
    .start   (start),
    .bin     (bus.value),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd)
  );
  // remember the last captured value; the first idle cycle after reset always converts
  always_ff @(posedge clk_cpu) begin
    if (!rst_n) begin
      last  <= '0;
      first <= 1'b1;
    end else if (start) begin
      last  <= bus.value;
      first <= 1'b0;
    end
  end
  // display register and ovf load together, only when a conversion completes
  always_ff @(posedge clk_cpu) begin
    if (!rst_n) begin
      disp    <= '0;
      bus.ovf <= 1'b0;
    end else if (done) begin
      disp    <= |bcd[39:32] ? DISP_MAX : bcd[31:0];
      bus.ovf <= |bcd[39:32];
    end
  end
  // expired tracks the raw input, independent of the converter
  always_ff @(posedge clk_cpu) bus.expired <= rst_n && bus.value == 32'd0;
  // scan prescaler and digit index
  always_ff @(posedge clk_cpu) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= idx + 3'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end
  // an and seg registered from the same index so they always change together
  always_ff @(posedge clk_cpu) begin
    if (!rst_n) begin
      bus.an  <= 8'hFE;
      bus.seg <= SEG_TABLE[0];
    end else begin
      bus.an  <= ~(8'b1 << idx);
      bus.seg <= blank ? SEG_BLANK : seg_of(digit);
    end
  end
endmodule

// File: doc/timer_display.md
TIMER_DISPLAY -- requirements
Module: timer_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk_cpu cycles each digit is driven (minimum 2).
REQ-002 SHALL have port clk_cpu  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port value  input  32  countdown value from the game timer, unsigned binary.
REQ-005 SHALL have port blank_zeros  input  1  1 = suppress leading zeros (digit 0 never blanked).
REQ-006 SHALL have port seg  output  8  active-low segments; seg[6:0] = g..a, seg[7] = dp.
REQ-007 SHALL have port an  output  8  active-low digit enables; an[i] selects digit i (0 = least significant).
REQ-008 SHALL have port ovf  output  1  displayed value saturated (value > 99999999).
REQ-009 SHALL have port expired  output  1  registered flag, value == 0 at the previous clk_cpu edge.

Function
REQ-010 SHALL convert binary to BCD sequentially (shift-add-3), one bit per cycle, with FSM states IDLE, SHIFT, DONE.
REQ-011 In IDLE, SHALL capture value into a shadow register and enter SHIFT when value != last converted value, or on the first cycle after reset.
REQ-012 SHIFT SHALL last exactly 32 cycles, then go to DONE; DONE SHALL last 1 cycle, then return to IDLE.
REQ-013 Latency from capture edge to display-register update SHALL be 33 cycles.
REQ-014 value changes during SHIFT/DONE SHALL be ignored; the in-flight conversion completes, and IDLE recaptures on its next cycle.
REQ-015 BCD result SHALL be 10 digits (40 bits); if digits 9..8 are non-zero, the display register SHALL load 99999999 and ovf SHALL be 1; otherwise it loads digits 7..0 and ovf is 0.
REQ-016 Display register and ovf SHALL update atomically in DONE only; no partial result is ever shown.
REQ-017 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; at the wrap, the digit index (3 bits) SHALL increment, 7 wrapping to 0.
REQ-018 an SHALL have exactly one zero bit, at the current digit index; the output is registered.
REQ-019 seg SHALL be the registered decode of the current digit: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, dp off).
REQ-020 When blank_zeros=1, SHALL drive digit i>0 as seg=FF if it and all digits above it are zero.
REQ-021 an/seg SHALL change in the same cycle (no ghosting cycle with mismatched pair).
REQ-022 expired SHALL be independent of the conversion FSM.

Reset
REQ-023 With rst_n=0 at an edge, SHALL set: FSM=IDLE, shadow/last value=0, display register=0, prescaler=0, digit index=0, ovf=0, expired=0, an=FE, seg=C0.
REQ-024 Reset asserted mid-conversion SHALL abandon it; the display register SHALL read 0.
REQ-025 First cycle after reset release SHALL force a conversion per REQ-011.

Structure
REQ-026 Package timer_display_pkg SHALL hold the FSM state enum, the 10-entry segment table, and the SEG_BLANK (FF) constant.
REQ-027 The sequential converter SHALL be sub-module bin2bcd_seq (start/bin in; busy/done/bcd[39:0] out); scan and decode stay in timer_display.
REQ-028 Total RTL SHALL fall within 120-400 lines.

Verification (SCAN_DIV=4 unless noted)
REQ-029 Reset then value=0, blank_zeros=1 -> after 33 cycles, digit 0 seg=C0, digits 1..7 seg=FF; expired=1.
REQ-030 value=12345678, blank_zeros=0 -> 33 cycles later, digits 7..0 show 1,2,3,4,5,6,7,8; ovf=0; an cycles FE,FD,..,7F with a 4-cycle dwell, then wraps to FE.
REQ-031 value=100000000 -> all digits show 9 (seg=90); ovf=1; value=99999999 -> ovf=0 after reconversion.
REQ-032 value 500 -> 499 at cycle 10 of SHIFT -> display shows 500 after 33 cycles, then 499 after a further 33 cycles plus one IDLE cycle.
REQ-033 rst_n low at SHIFT cycle 20 -> next edge: an=FE, seg=C0, ovf=0; conversion restarts after release.
REQ-034 value=1000, blank_zeros toggled 1->0 -> digits 4..7 change FF->C0 on their next scan slot, without reconversion.
